fft_bin_scanner: RTL and testbench

- Downstream consumer of the 8-point DIT FFT core (dit_fft_8).
- Drives the core's bin-select input `sel`, captures each selected bin (yr, yi), and computes its power re²+im².
- Tracks the peak-power bin over one full scan, then presents the result on a valid/ready output.
- Turns the core's random-access bin output into a single spectral-peak result for later stages.

---
 rtl/fft_pkg.sv | 16 +
 rtl/fft_bin_scanner_if.sv | 34 +++
 rtl/fft_bin_power.sv | 23 ++
 rtl/fft_bin_scanner.sv | 159 +++++++++++++++
 tb/tb_fft_bin_scanner.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared FFT constants and the scanner state type.
// Contents: FFT_N, FFT_W, FFT_SW and FFT_PW (power width), plus scan_state_t.
package fft_pkg;

  localparam int FFT_N  = 8;
  localparam int FFT_W  = 9;
  localparam int FFT_SW = 3;
  localparam int FFT_PW = 2 * FFT_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/fft_bin_scanner_if.sv
// Scanner bus. It bundles the scan control, the FFT-core bin access and the result handshake.
//   start/busy                    : scan request and status
//   sel -> yr/yi                  : bin select to the FFT core and the returned bin
//   res_valid/res_ready           : result handshake
//   peak_bin/peak_pow             : result payload
// The master modport is the scanner. The slave modport is the environment (core plus consumer).
interface fft_bin_scanner_if
  import fft_pkg::*;
#(
  parameter int W  = FFT_W,
  parameter int SW = FFT_SW
);

  logic                start;
  logic                busy;
  logic [SW-1:0]       sel;
  logic signed [W-1:0] yr;
  logic signed [W-1:0] yi;
  logic                res_valid;
  logic                res_ready;
  logic [SW-1:0]       peak_bin;
  logic [2*W-1:0]      peak_pow;

  modport master (
    input  start, yr, yi, res_ready,
    output busy, sel, res_valid, peak_bin, peak_pow
  );

  modport slave (
    output start, yr, yi, res_ready,
    input  busy, sel, res_valid, peak_bin, peak_pow
  );

endinterface

// File: rtl/fft_bin_power.sv
// Combinational bin power: p = yr^2 + yi^2, returned as unsigned 2W bits.
//   yr, yi : signed W-bit bin components
//   p      : unsigned 2W-bit power
// Each square fits in 2W signed bits. The sum can reach 2^(2W-1), so it is
// formed as an unsigned add. That keeps the top bit as magnitude rather than sign.
module fft_bin_power #(
  parameter int W = 9
) (
  input  logic signed [W-1:0] yr,
  input  logic signed [W-1:0] yi,
  output logic [2*W-1:0]      p
);

  logic signed [2*W-1:0] yr_x, yi_x;
  logic signed [2*W-1:0] rr, ii;

  assign yr_x = {{W{yr[W-1]}}, yr};
  assign yi_x = {{W{yi[W-1]}}, yi};
  assign rr   = yr_x * yr_x;
  assign ii   = yi_x * yi_x;
  assign p    = $unsigned(rr) + $unsigned(ii);

endmodule

// File: rtl/fft_bin_scanner.sv
// Scans every bin of the FFT core through sel and computes each bin's power.
// It tracks the peak-power bin and presents it on a valid/ready handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fft_bin_scanner_if.master (start/busy, sel/yr/yi, result handshake)
// Parameters: W (bin width), N (bins, power of two), SEL_LAT (sel-to-data latency, 0..3).
// Build option: defining FFT_SCAN_SKIP_DC_EN keeps bin 0 out of the peak search.
//
// state | meaning
// IDLE  | waiting for start, sel parked at 0
// SCAN  | issuing bins on sel and sampling them SEL_LAT cycles later
// DONE  | result held on res_valid until res_ready
module fft_bin_scanner
  import fft_pkg::*;
#(
  parameter int W       = FFT_W,
  parameter int N       = FFT_N,
  parameter int SEL_LAT = 1,
  localparam int SW     = $clog2(N),
  localparam int PW     = 2 * W
) (
  input logic                clk,
  input logic                rst_n,
  fft_bin_scanner_if.master  bus
);

`ifdef FFT_SCAN_SKIP_DC_EN
  localparam bit SKIP_DC = 1'b1;
`else
  localparam bit SKIP_DC = 1'b0;
`endif

  scan_state_t   state, state_nxt;
  logic          issuing;
  logic [SW-1:0] sel_q;
  logic          first;
  logic [PW-1:0] max_pow;
  logic [SW-1:0] max_bin;
  logic [SW-1:0] peak_bin_q;
  logic [PW-1:0] peak_pow_q;
  logic          samp_v;
  logic [SW-1:0] samp_idx;
  logic [PW-1:0] p;
  logic          start_acc, issue_v, last_samp, handshake, eligible, upd;

  assign start_acc = (state == IDLE) && bus.start;
  assign issue_v   = (state == SCAN) && issuing;
  assign last_samp = samp_v && (samp_idx == SW'(N - 1));
  assign handshake = (state == DONE) && bus.res_ready;
  assign eligible  = !SKIP_DC || (samp_idx != '0);
  assign upd       = samp_v && eligible && (first || (p > max_pow));

  fft_bin_power #(.W(W)) u_power (
    .yr (bus.yr),
    .yi (bus.yi),
    .p  (p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.busy      = 1'b0;
    bus.res_valid = 1'b0;
    case (state)
      IDLE: if (bus.start) state_nxt = SCAN;
      SCAN: begin
        bus.busy = 1'b1;
        if (last_samp) state_nxt = DONE;
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.res_valid = 1'b1;
        if (bus.res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // sel sweeps 0..N-1, holds N-1 until the result is taken, then parks at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= '0;
      issuing <= 1'b0;
    end else if (start_acc) begin
      sel_q   <= '0;
      issuing <= 1'b1;
    end else if (issue_v) begin
      if (sel_q == SW'(N - 1)) issuing <= 1'b0;
      else                     sel_q   <= sel_q + 1'b1;
    end else if (handshake) begin
      sel_q <= '0;
    end
  end

  assign bus.sel = sel_q;

  // The delay line pairs each issued bin index with the yr/yi it produces SEL_LAT cycles later.
  generate
    if (SEL_LAT == 0) begin : g_nodelay
      assign samp_v   = issue_v;
      assign samp_idx = sel_q;
    end else begin : g_delay
      logic [SEL_LAT-1:0] dl_v;
      logic [SW-1:0]      dl_idx [SEL_LAT];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dl_v <= '0;
          for (int i = 0; i < SEL_LAT; i++) dl_idx[i] <= '0;
        end else if (start_acc) begin
          dl_v <= '0;
        end else begin
          dl_v[0]   <= issue_v;
          dl_idx[0] <= sel_q;
          for (int i = 1; i < SEL_LAT; i++) begin
            dl_v[i]   <= dl_v[i-1];
            dl_idx[i] <= dl_idx[i-1];
          end
        end
      end

      assign samp_v   = dl_v[SEL_LAT-1];
      assign samp_idx = dl_idx[SEL_LAT-1];
    end
  endgenerate

  // A strict compare keeps the lowest index on ties. The result is taken on the
  // last sample, folding in that sample's own update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first      <= 1'b0;
      max_pow    <= '0;
      max_bin    <= '0;
      peak_bin_q <= '0;
      peak_pow_q <= '0;
    end else if (start_acc) begin
      first   <= 1'b1;
      max_pow <= '0;
      max_bin <= '0;
    end else begin
      if (upd) begin
        first   <= 1'b0;
        max_pow <= p;
        max_bin <= samp_idx;
      end
      if (last_samp) begin
        peak_bin_q <= upd ? samp_idx : max_bin;
        peak_pow_q <= upd ? p : max_pow;
      end
    end
  end

  assign bus.peak_bin = peak_bin_q;
  assign bus.peak_pow = peak_pow_q;

endmodule

// File: tb/tb_fft_bin_scanner.sv
module tb_fft_bin_scanner;
  import fft_pkg::*;

`ifdef FFT_SCAN_SKIP_DC_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  logic signed [8:0] br [8];
  logic signed [8:0] bi [8];
  logic [2:0]        sel_d;
  int                exp_bin, exp_pow, n;

  fft_bin_scanner_if #(.W(9), .SW(3)) bus ();

  fft_bin_scanner #(.W(9), .N(8), .SEL_LAT(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // FFT core model: the bin selected by sel appears one cycle later.
  always @(posedge clk) sel_d <= bus.sel;
  assign bus.yr = br[sel_d];
  assign bus.yi = bi[sel_d];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int pow_of(input int i);
    int a, b;
    a = br[i];
    b = bi[i];
    return a * a + b * b;
  endfunction

  // Peak search: highest power wins, first seen wins ties.
  task automatic model();
    int s;
    s = SKIP ? 1 : 0;
    exp_bin = s;
    exp_pow = pow_of(s);
    for (int i = s + 1; i < 8; i++)
      if (pow_of(i) > exp_pow) begin
        exp_bin = i;
        exp_pow = pow_of(i);
      end
  endtask

  task automatic fill_const(input int r, input int im);
    for (int i = 0; i < 8; i++) begin
      br[i] = 9'(r);
      bi[i] = 9'(im);
    end
  endtask

  task automatic fill_rand(input int span);
    for (int i = 0; i < 8; i++) begin
      br[i] = 9'(int'($urandom_range(2 * span, 0)) - span);
      bi[i] = 9'(int'($urandom_range(2 * span, 0)) - span);
    end
  endtask

  // Called at a negedge. Starts a scan and waits for res_valid. It can check the
  // sel sweep and latency, compares against the model, and acks if asked.
  task automatic scan(input string tag, input bit chk_seq, input bit ack);
    model();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (!bus.res_valid && n < 40) begin
      if (chk_seq) chk({tag, "_sel"}, 32'(bus.sel), (n < 7) ? n : 7);
      n++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, n, 9);
    chk({tag, "_bin"}, 32'(bus.peak_bin), exp_bin);
    chk({tag, "_pow"}, 32'(bus.peak_pow), exp_pow);
    if (ack) begin
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      chk({tag, "_valid_drop"}, 32'(bus.res_valid), 0);
      chk({tag, "_idle"}, {30'd0, bus.busy, |bus.sel}, 0);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.res_ready = 1'b0;
    fill_const(0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_sel", 32'(bus.sel), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_valid", 32'(bus.res_valid), 0);
    chk("rst_bin", 32'(bus.peak_bin), 0);
    chk("rst_pow", 32'(bus.peak_pow), 0);

    // Single peak at bin 5.
    fill_const(1, 0);
    br[5] = 9'sd3;
    bi[5] = -9'sd4;
    scan("single", 1'b1, 1'b1);
    chk("single_bin_const", 32'(bus.peak_bin), 5);
    chk("single_pow_const", 32'(bus.peak_pow), 25);

    // Tie at extreme magnitude.
    fill_const(0, 0);
    br[2] = -9'sd256; bi[2] = -9'sd256;
    br[6] = -9'sd256; bi[6] = -9'sd256;
    scan("tie", 1'b0, 1'b1);
    chk("tie_bin_const", 32'(bus.peak_bin), 2);
    chk("tie_pow_const", 32'(bus.peak_pow), 131072);

    // All zero.
    fill_const(0, 0);
    scan("zero", 1'b0, 1'b1);
    chk("zero_bin_const", 32'(bus.peak_bin), SKIP ? 1 : 0);
    chk("zero_pow_const", 32'(bus.peak_pow), 0);

    // DC-dominant input.
    fill_const(0, 0);
    br[0] = 9'sd100;
    br[3] = 9'sd2; bi[3] = 9'sd2;
    scan("dc", 1'b0, 1'b1);
    chk("dc_bin_const", 32'(bus.peak_bin), SKIP ? 3 : 0);
    chk("dc_pow_const", 32'(bus.peak_pow), SKIP ? 8 : 10000);

    // Backpressure. Outputs hold and an extra start is dropped. A start on the
    // handshake edge is ignored; the start on the next edge is accepted.
    fill_rand(256);
    scan("bp", 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      bus.start = (k == 2);
      @(negedge clk);
      chk("bp_hold_valid", 32'(bus.res_valid), 1);
      chk("bp_hold_bin", 32'(bus.peak_bin), exp_bin);
      chk("bp_hold_pow", 32'(bus.peak_pow), exp_pow);
    end
    bus.start     = 1'b1;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("bp_ack_valid", 32'(bus.res_valid), 0);
    chk("bp_ack_busy", 32'(bus.busy), 0);
    chk("bp_keep_bin", 32'(bus.peak_bin), exp_bin);
    bus.start = 1'b0;
    fill_rand(20);
    scan("bp_next", 1'b1, 1'b1);

    // Reset in the middle of a scan.
    fill_rand(256);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.sel != 3'd4 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("mid_reach_sel4", 32'(bus.sel), 4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sel", 32'(bus.sel), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_valid", 32'(bus.res_valid), 0);
    chk("mid_rst_bin", 32'(bus.peak_bin), 0);
    chk("mid_rst_pow", 32'(bus.peak_pow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill_rand(256);
    scan("after_rst", 1'b1, 1'b1);

    // Random scans: full range, and a narrow range that forces ties.
    for (int t = 0; t < 12; t++) begin
      fill_rand((t % 2 == 0) ? 256 : 1);
      scan("rand", 1'b0, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
